// File: rtl/spi_master_param_if.sv
// spi_master_param_if: controller-side and serial-side signals of spi_master_param.
// The master modport is the SPI master's view; the slave modport is the
// controlling logic / off-block side that drives requests and MISO.
interface spi_master_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_W      = 2
);
  logic                  start;
  logic [SEL_W-1:0]      slaveSelect;
  logic                  cpol;
  logic                  cpha;
  logic [DATA_WIDTH-1:0] masterDataToSend;
  logic [DATA_WIDTH-1:0] masterDataReceived;
  logic                  busy;
  logic                  done;
  logic                  SCLK;
  logic [NUM_SLAVES-1:0] CS;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  start, slaveSelect, cpol, cpha, masterDataToSend, MISO,
    output masterDataReceived, busy, done, SCLK, CS, MOSI
  );

  modport slave (
    output start, slaveSelect, cpol, cpha, masterDataToSend, MISO,
    input  masterDataReceived, busy, done, SCLK, CS, MOSI
  );
endinterface

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master, all four CPOL/CPHA modes,
// configurable word width, slave count and SCLK half-period (CLK_DIV).
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN selects LSB-first bit order
// (received bits fill from the MSB); default is MSB first.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_W      = 2,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_master_param_if.master    bus
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, DONE} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  sel_ok;

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return w[0];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w);
    return w >> 1;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] w, input logic b);
    return {b, w[DATA_WIDTH-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w);
    return w << 1;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] w, input logic b);
    return {w[DATA_WIDTH-2:0], b};
  endfunction
`endif

  // Requests to a non-existent slave are dropped without leaving IDLE
  always_comb sel_ok = ({1'b0, bus.slaveSelect} < (SEL_W + 1)'(NUM_SLAVES));

  // Transaction sequencer: state, counters, shift registers and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      div_cnt                <= '0;
      edge_cnt               <= '0;
      tx_sh                  <= '0;
      rx_sh                  <= '0;
      cpol_q                 <= 1'b0;
      cpha_q                 <= 1'b0;
      bus.SCLK               <= 1'b0;
      bus.CS                 <= '1;
      bus.MOSI               <= 1'b0;
      bus.busy               <= 1'b0;
      bus.done               <= 1'b0;
      bus.masterDataReceived <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && sel_ok) begin
            cpol_q   <= bus.cpol;
            cpha_q   <= bus.cpha;
            bus.SCLK <= bus.cpol;
            bus.CS   <= ~(NUM_SLAVES'(1) << bus.slaveSelect);
            bus.busy <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= '0;
            rx_sh    <= '0;
            // CPHA=0 presents the first bit before the first (sampling) edge
            if (!bus.cpha) begin
              bus.MOSI <= first_bit(bus.masterDataToSend);
              tx_sh    <= shift_tx(bus.masterDataToSend);
            end else begin
              tx_sh    <= bus.masterDataToSend;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= TRANSFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        TRANSFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            bus.SCLK <= ~bus.SCLK;
            // Even edge_cnt is a leading edge (edges counted from zero)
            if (!edge_cnt[0]) begin
              if (cpha_q) begin
                bus.MOSI <= first_bit(tx_sh);
                tx_sh    <= shift_tx(tx_sh);
              end else begin
                rx_sh <= shift_rx(rx_sh, bus.MISO);
              end
            end else begin
              if (cpha_q) begin
                rx_sh <= shift_rx(rx_sh, bus.MISO);
              end else if (edge_cnt != EDGE_LAST) begin
                bus.MOSI <= first_bit(tx_sh);
                tx_sh    <= shift_tx(tx_sh);
              end
            end
            if (edge_cnt == EDGE_LAST) begin
              edge_cnt <= '0;
              state    <= HOLD;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt                <= '0;
            bus.CS                 <= '1;
            bus.busy               <= 1'b0;
            bus.done               <= 1'b1;
            bus.masterDataReceived <= rx_sh;
            state                  <= DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
